lcd_sequencer: RTL
==================

Name: lcd_sequencer

Overview:
Command/character sequencer that sits directly upstream of the LCD bus-driver stage and drives its request interface (DatoInit, DatoLCD, Init, Ejecutar, Linea2, Cuenta).
After reset it waits for LCD power-up, then issues the HD44780 init command list. On each Start it writes a 32-character frame, 16 characters per line, read from an external text buffer.
It consumes the driver's InitEscrito/CharEscrito acknowledge pulses.

Parameters:
POWERUP_CYCLES, 1500000, wait after reset before the first command (15 ms at 100 MHz).
CMD_GAP, 5000, idle cycles after each acknowledged transaction (50 us).
CLEAR_GAP, 200000, idle cycles after the clear-display command 0x01 (2 ms).
ACK_TIMEOUT, 4000000, maximum cycles to wait for an acknowledge before flagging an error.

Ports:
Clk  in  1  system clock, 100 MHz; all state updates on the rising edge.
Reset  in  1  asynchronous, active-low reset.
Start  in  1  request a frame refresh; sampled only in IDLE.
CharData  in  8  character at CharAddr; combinational read, valid in the same cycle.
InitEscrito  in  1  driver acknowledge for a command write, one-cycle pulse.
CharEscrito  in  1  driver acknowledge for a character write, one-cycle pulse.
CharAddr  out  5  text buffer read address, 0..31.
DatoInit  out  8  command byte to the driver.
DatoLCD  out  8  character byte to the driver.
Init  out  1  command write request, held as a level.
Ejecutar  out  1  character write request, held as a level.
Linea2  out  1  marks the current character as the last one on line 1.
Cuenta  out  1  qualifies the line-2 address command in the driver; asserted together with Linea2.
Ready  out  1  high in IDLE.
Error  out  1  sticky acknowledge-timeout flag.

Behaviour:
- Reset low, at any time including mid-transaction:
  - All outputs go to 0 immediately.
  - State goes to PWRUP; all counters and the command/character indices clear.
  - Error clears only on reset.
- PWRUP:
  - A wait counter runs to POWERUP_CYCLES-1.
  - Then go to CMD with command index 0.
- CMD:
  - Init=1; DatoInit=ROM[idx]. The ROM is 0x38, 0x0C, 0x06, 0x01 for idx 0..3, and 0x80 for idx 4 (home).
  - On an InitEscrito sample at a rising edge: drop Init in the next cycle and go to GAP.
  - The gap is CLEAR_GAP for 0x01, otherwise CMD_GAP.
- GAP, after a command:
  - idx<3: idx++ and return to CMD.
  - idx==3: go to IDLE.
  - idx==4 (home): go to CHAR with CharAddr=0.
- IDLE:
  - Ready=1.
  - Start=1 sets idx=4 and goes to CMD; Ready drops in the same cycle.
  - Start outside IDLE is ignored and never queued.
- CHAR:
  - Ejecutar=1.
  - DatoLCD is registered from CharData on entry and held stable for the whole request.
  - When CharAddr==15: Linea2=1 and Cuenta=1 for the full request.
  - On a CharEscrito sample: drop Ejecutar, Linea2 and Cuenta in the next cycle, then run CMD_GAP.
  - After the gap: CharAddr<31 increments CharAddr and returns to CHAR; CharAddr==31 goes to IDLE with CharAddr wrapping to 0.
- Request rules:
  - Only one of Init or Ejecutar is high at any time.
  - A request stays high until its acknowledge is seen, and is low for at least CMD_GAP cycles before the next request.
  - An acknowledge of the wrong type, or one arriving outside CMD/CHAR, is ignored.
- Timeout:
  - The acknowledge wait counter clears at each request start.
  - Reaching ACK_TIMEOUT sets Error=1, drops the request and goes to IDLE. A later Start retries the frame normally.
- Counter widths: one shared 22-bit wait/timeout counter, which must cover the largest parameter.

Test Plan:
- Bench overrides: POWERUP_CYCLES=20, CMD_GAP=4, CLEAR_GAP=10, ACK_TIMEOUT=50. The driver model acknowledges 3 cycles after a request rises.
- Reset release -> first Init rise exactly 20 cycles later. DatoInit sequence is 0x38, 0x0C, 0x06, 0x01. Gap after 0x01 is ≥10 cycles. Ready=1 afterwards with Error=0.
- Start pulse with buffer "ABCDEFGHIJKLMNOPabcdefghijklmnop":
  - Command 0x80 is issued first, then 32 Ejecutar requests.
  - DatoLCD carries 0x41..0x50, then 0x61..0x70.
  - Linea2=Cuenta=1 only during the 'P' request.
  - Ready returns with CharAddr=0.
- The driver withholds CharEscrito on char 5 -> after 50 cycles Error=1, Ejecutar=0 and Ready=1. A subsequent Start completes a full frame with Error still 1.
- Reset asserted during char 10 -> outputs are 0 immediately. After release, the full power-up and init sequence repeats.
- Start held high continuously, plus a stray InitEscrito during CHAR -> exactly one frame per IDLE entry, and the stray pulse does not advance CharAddr.

Source files
------------

// File: rtl/lcd_sequencer.sv
// Power-up, HD44780 init and 32-character frame sequencer for the LCD bus driver. All outputs are registered.
// Requests are levels held until the matching acknowledge arrives; a missing acknowledge times out to IDLE with Error set.
module lcd_sequencer #(
   parameter int POWERUP_CYCLES = 1500000,
   parameter int CMD_GAP        = 5000,
   parameter int CLEAR_GAP      = 200000,
   parameter int ACK_TIMEOUT    = 4000000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
   input  logic [7:0] CharData,
   input  logic       InitEscrito,
   input  logic       CharEscrito,
   output logic [4:0] CharAddr,
   output logic [7:0] DatoInit,
   output logic [7:0] DatoLCD,
   output logic       Init,
   output logic       Ejecutar,
   output logic       Linea2,
   output logic       Cuenta,
   output logic       Ready,
   output logic       Error
);

   typedef enum logic [2:0] {
      s_pwrup,
      s_cmd,
      s_cmd_gap,
      s_idle,
      s_char_ld,
      s_char,
      s_char_gap
   } state_t;

   localparam logic [21:0] PWR_LAST   = 22'(POWERUP_CYCLES - 1);
   localparam logic [21:0] GAP_LAST   = 22'(CMD_GAP - 1);
   localparam logic [21:0] CLEAR_LAST = 22'(CLEAR_GAP - 1);
   localparam logic [21:0] ACK_LAST   = 22'(ACK_TIMEOUT - 1);

   state_t      state;
   logic [21:0] cnt;
   logic [2:0]  idx;
   logic [21:0] gap_last;

   function automatic logic [7:0] rom(input logic [2:0] i);
      case (i)
         3'd0:    rom = 8'h38;
         3'd1:    rom = 8'h0C;
         3'd2:    rom = 8'h06;
         3'd3:    rom = 8'h01;
         default: rom = 8'h80;
      endcase
   endfunction

   // Index 3 is the clear-display command, which needs the long settle time.
   assign gap_last = (idx == 3'd3) ? CLEAR_LAST : GAP_LAST;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state    <= s_pwrup;
         cnt      <= '0;
         idx      <= '0;
         CharAddr <= '0;
         DatoInit <= '0;
         DatoLCD  <= '0;
         Init     <= 1'b0;
         Ejecutar <= 1'b0;
         Linea2   <= 1'b0;
         Cuenta   <= 1'b0;
         Ready    <= 1'b0;
         Error    <= 1'b0;
      end else begin
         case (state)
            s_pwrup: begin
               if (cnt == PWR_LAST) begin
                  cnt      <= '0;
                  idx      <= '0;
                  Init     <= 1'b1;
                  DatoInit <= rom(3'd0);
                  state    <= s_cmd;
               end else begin
                  cnt <= cnt + 22'd1;
               end
            end
            s_cmd: begin
               if (InitEscrito) begin
                  Init  <= 1'b0;
                  cnt   <= '0;
                  state <= s_cmd_gap;
               end else if (cnt == ACK_LAST) begin
                  Init     <= 1'b0;
                  Error    <= 1'b1;
                  Ready    <= 1'b1;
                  CharAddr <= '0;
                  cnt      <= '0;
                  state    <= s_idle;
               end else begin
                  cnt <= cnt + 22'd1;
               end
            end
            s_cmd_gap: begin
               if (cnt == gap_last) begin
                  cnt <= '0;
                  if (idx == 3'd4) begin
                     CharAddr <= '0;
                     state    <= s_char_ld;
                  end else if (idx == 3'd3) begin
                     Ready <= 1'b1;
                     state <= s_idle;
                  end else begin
                     idx      <= idx + 3'd1;
                     Init     <= 1'b1;
                     DatoInit <= rom(idx + 3'd1);
                     state    <= s_cmd;
                  end
               end else begin
                  cnt <= cnt + 22'd1;
               end
            end
            s_idle: begin
               if (Start) begin
                  Ready    <= 1'b0;
                  idx      <= 3'd4;
                  CharAddr <= '0;
                  Init     <= 1'b1;
                  DatoInit <= rom(3'd4);
                  cnt      <= '0;
                  state    <= s_cmd;
               end
            end
            // One load cycle so the buffer read reflects the freshly updated CharAddr.
            s_char_ld: begin
               DatoLCD  <= CharData;
               Ejecutar <= 1'b1;
               Linea2   <= (CharAddr == 5'd15);
               Cuenta   <= (CharAddr == 5'd15);
               cnt      <= '0;
               state    <= s_char;
            end
            s_char: begin
               if (CharEscrito) begin
                  Ejecutar <= 1'b0;
                  Linea2   <= 1'b0;
                  Cuenta   <= 1'b0;
                  cnt      <= '0;
                  state    <= s_char_gap;
               end else if (cnt == ACK_LAST) begin
                  Ejecutar <= 1'b0;
                  Linea2   <= 1'b0;
                  Cuenta   <= 1'b0;
                  Error    <= 1'b1;
                  Ready    <= 1'b1;
                  CharAddr <= '0;
                  cnt      <= '0;
                  state    <= s_idle;
               end else begin
                  cnt <= cnt + 22'd1;
               end
            end
            s_char_gap: begin
               if (cnt == GAP_LAST) begin
                  cnt <= '0;
                  if (CharAddr == 5'd31) begin
                     CharAddr <= '0;
                     Ready    <= 1'b1;
                     state    <= s_idle;
                  end else begin
                     CharAddr <= CharAddr + 5'd1;
                     state    <= s_char_ld;
                  end
               end else begin
                  cnt <= cnt + 22'd1;
               end
            end
            default: state <= s_pwrup;
         endcase
      end
   end

endmodule
